// File: rtl/matmul_systolic_param.sv
// SIZE x SIZE signed systolic matrix multiplier: operand fetch with address wrap,
// skewed A/B injection, accumulate across passes, optional saturation, row-serial drain.
module matmul_systolic_param #(
    parameter int unsigned DWIDTH    = 8,
    parameter int unsigned AWIDTH    = 7,
    parameter int unsigned SIZE      = 8,
    parameter int unsigned LOG2_SIZE = 3,
    parameter int unsigned ACC_WIDTH = 2*DWIDTH+8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_mat_mul,
    input  logic                     accumulate,
    input  logic                     sat_en,
    input  logic [7:0]               k_len,
    input  logic [AWIDTH-1:0]        a_base,
    input  logic [AWIDTH-1:0]        b_base,
    output logic [AWIDTH-1:0]        a_addr,
    output logic [AWIDTH-1:0]        b_addr,
    output logic                     a_en,
    output logic                     b_en,
    input  logic [SIZE*DWIDTH-1:0]   a_data,
    input  logic [SIZE*DWIDTH-1:0]   b_data,
    output logic                     busy,
    output logic                     done_mat_mul,
    output logic [SIZE*DWIDTH-1:0]   c_data_row,
    output logic                     c_valid,
    output logic [LOG2_SIZE-1:0]     c_row
);

    localparam int unsigned CNT_W = 8;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((64'd1 << (DWIDTH-1)) - 64'd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {IDLE, FETCH, FLUSH, DRAIN, DONE} state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [7:0]              k_q, k_n;
    logic                    sat_q, sat_n;
    logic                    acc_clear;
    logic                    fetch_n;
    logic                    data_vld;
    logic [AWIDTH-1:0]       a_addr_n, b_addr_n;
    logic                    c_valid_n;
    logic [LOG2_SIZE-1:0]    c_row_n;
    logic [SIZE*DWIDTH-1:0]  c_data_n;

    logic signed [DWIDTH-1:0]    a_bus   [SIZE][SIZE];
    logic signed [DWIDTH-1:0]    b_bus   [SIZE][SIZE];
    logic signed [ACC_WIDTH-1:0] acc_arr [SIZE][SIZE];

    function automatic logic [DWIDTH-1:0] to_out(input logic signed [ACC_WIDTH-1:0] v,
                                                 input logic sat);
        if (sat && (v > SAT_MAX)) return SAT_MAX[DWIDTH-1:0];
        if (sat && (v < SAT_MIN)) return SAT_MIN[DWIDTH-1:0];
        return v[DWIDTH-1:0];
    endfunction

    // Next state plus next values of every registered output (outputs track state_n)
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        k_n       = k_q;
        sat_n     = sat_q;
        acc_clear = 1'b0;
        unique case (state)
            IDLE: if (start_mat_mul && (k_len != 8'd0)) begin
                state_n   = FETCH;
                cnt_n     = '0;
                k_n       = k_len;
                sat_n     = sat_en;
                acc_clear = !accumulate;
            end
            FETCH: if (cnt == (k_q - 8'd1)) begin
                state_n = FLUSH;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
            FLUSH: if (cnt == CNT_W'(2*SIZE-2)) begin
                state_n = DRAIN;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
            DRAIN: if (cnt == CNT_W'(SIZE-1)) begin
                state_n = DONE;
                cnt_n   = '0;
            end else begin
                cnt_n = cnt + CNT_W'(1);
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        fetch_n  = (state_n == FETCH);
        a_addr_n = '0;
        b_addr_n = '0;
        if (fetch_n) begin
            a_addr_n = (state == IDLE) ? a_base : a_addr + AWIDTH'(1);
            b_addr_n = (state == IDLE) ? b_base : b_addr + AWIDTH'(1);
        end

        c_valid_n = (state_n == DRAIN);
        c_row_n   = c_valid_n ? cnt_n[LOG2_SIZE-1:0] : '0;
        c_data_n  = '0;
        if (c_valid_n) begin
            for (int j = 0; j < SIZE; j++) begin
                c_data_n[j*DWIDTH +: DWIDTH] = to_out(acc_arr[c_row_n][j], sat_n);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            k_q          <= '0;
            sat_q        <= 1'b0;
            a_en         <= 1'b0;
            b_en         <= 1'b0;
            a_addr       <= '0;
            b_addr       <= '0;
            data_vld     <= 1'b0;
            busy         <= 1'b0;
            done_mat_mul <= 1'b0;
            c_valid      <= 1'b0;
            c_row        <= '0;
            c_data_row   <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            k_q          <= k_n;
            sat_q        <= sat_n;
            a_en         <= fetch_n;
            b_en         <= fetch_n;
            a_addr       <= a_addr_n;
            b_addr       <= b_addr_n;
            data_vld     <= a_en;
            busy         <= (state_n != IDLE);
            done_mat_mul <= (state_n == DONE);
            c_valid      <= c_valid_n;
            c_row        <= c_row_n;
            c_data_row   <= c_data_n;
        end
    end

    // Edge skew: lane i of A and lane i of B are delayed i cycles; idle lanes inject zero
    for (genvar i = 0; i < SIZE; i++) begin : g_skew
        logic signed [DWIDTH-1:0] a_in, b_in;
        assign a_in = data_vld ? a_data[i*DWIDTH +: DWIDTH] : '0;
        assign b_in = data_vld ? b_data[i*DWIDTH +: DWIDTH] : '0;
        if (i == 0) begin : g_direct
            assign a_bus[0][0] = a_in;
            assign b_bus[0][0] = b_in;
        end else begin : g_delay
            logic signed [DWIDTH-1:0] a_sr [i];
            logic signed [DWIDTH-1:0] b_sr [i];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int d = 0; d < i; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else begin
                    a_sr[0] <= a_in;
                    b_sr[0] <= b_in;
                    for (int d = 1; d < i; d++) begin
                        a_sr[d] <= a_sr[d-1];
                        b_sr[d] <= b_sr[d-1];
                    end
                end
            end
            assign a_bus[i][0] = a_sr[i-1];
            assign b_bus[0][i] = b_sr[i-1];
        end
    end

    // Processing elements: A moves right, B moves down, each PE accumulates a*b
    for (genvar i = 0; i < SIZE; i++) begin : g_row
        for (genvar j = 0; j < SIZE; j++) begin : g_pe
            logic signed [DWIDTH-1:0]    a_q, b_q;
            logic signed [ACC_WIDTH-1:0] acc_q;
            logic signed [2*DWIDTH-1:0]  prod;
            assign prod = a_q * b_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    acc_q <= '0;
                end else begin
                    a_q <= a_bus[i][j];
                    b_q <= b_bus[i][j];
                    if (acc_clear) acc_q <= '0;
                    else           acc_q <= acc_q + ACC_WIDTH'(prod);
                end
            end
            if (j < SIZE-1) begin : g_right
                assign a_bus[i][j+1] = a_q;
            end
            if (i < SIZE-1) begin : g_down
                assign b_bus[i+1][j] = b_q;
            end
            assign acc_arr[i][j] = acc_q;
        end
    end

endmodule
